// File: rtl/reg_bus_arbiter.sv
// Two-requester round-robin arbiter for a shared register bus.
// Each grant issues a one-cycle read/write strobe, waits WAIT_CYCLES, then pulses done.
module reg_bus_arbiter #(
    parameter int ADDR_W      = 3,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_done0,
    output logic              o_done1,
    output logic [DATA_W-1:0] o_rdata0,
    output logic [DATA_W-1:0] o_rdata1,
    output logic              o_rd_req,
    output logic              o_wr_req,
    output logic [ADDR_W-1:0] o_rwaddr,
    output logic [DATA_W-1:0] o_wdata,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);

    state_t            state_q, state_d;
    logic              win_q, win_d;
    logic              we_q, we_d;
    logic              last_q, last_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        we_d     = we_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        case (state_q)
            IDLE: begin
                if (i_req0 || i_req1) begin
                    // Under contention the requester not served last wins.
                    win_d   = (i_req0 && i_req1) ? ~last_q : i_req1;
                    we_d    = win_d ? i_we1    : i_we0;
                    addr_d  = win_d ? i_addr1  : i_addr0;
                    wdata_d = win_d ? i_wdata1 : i_wdata0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                cnt_d   = WAIT_LOAD;
                state_d = (WAIT_CYCLES == 0) ? DONE : WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d == DONE && state_q != DONE) begin
            last_d = win_q;
            if (!we_q) begin
                if (win_q) rdata1_d = i_rdata;
                else       rdata0_d = i_rdata;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            win_q    <= 1'b0;
            we_q     <= 1'b0;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            we_q     <= we_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign o_rd_req = (state_q == ACCESS) && !we_q;
    assign o_wr_req = (state_q == ACCESS) &&  we_q;
    assign o_done0  = (state_q == DONE)   && !win_q;
    assign o_done1  = (state_q == DONE)   &&  win_q;
    assign o_busy   = (state_q != IDLE);
    assign o_rwaddr = addr_q;
    assign o_wdata  = wdata_q;
    assign o_rdata0 = rdata0_q;
    assign o_rdata1 = rdata1_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Drives a WAIT_CYCLES=1 and a WAIT_CYCLES=0 arbiter with shared random stimulus and
// compares every output each cycle against a transaction-timeline reference model.
module tb_reg_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, we0, we1;
    logic [2:0] addr0, addr1;
    logic [7:0] wdata0, wdata1, rdata;

    logic       rd_a, wr_a, d0_a, d1_a, busy_a;
    logic [2:0] addr_a;
    logic [7:0] wd_a, r0_a, r1_a;
    logic       rd_b, wr_b, d0_b, d1_b, busy_b;
    logic [2:0] addr_b;
    logic [7:0] wd_b, r0_b, r1_b;

    always #5 clk = ~clk;

    reg_bus_arbiter #(.ADDR_W(3), .DATA_W(8), .WAIT_CYCLES(1)) dut_w1 (
        .i_clk(clk), .i_rst(rst),
        .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
        .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_done0(d0_a), .o_done1(d1_a), .o_rdata0(r0_a), .o_rdata1(r1_a),
        .o_rd_req(rd_a), .o_wr_req(wr_a), .o_rwaddr(addr_a), .o_wdata(wd_a),
        .i_rdata(rdata), .o_busy(busy_a)
    );

    reg_bus_arbiter #(.ADDR_W(3), .DATA_W(8), .WAIT_CYCLES(0)) dut_w0 (
        .i_clk(clk), .i_rst(rst),
        .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
        .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_done0(d0_b), .o_done1(d1_b), .o_rdata0(r0_b), .o_rdata1(r1_b),
        .o_rd_req(rd_b), .o_wr_req(wr_b), .o_rwaddr(addr_b), .o_wdata(wd_b),
        .i_rdata(rdata), .o_busy(busy_b)
    );

    logic [31:0] obs [2];
    assign obs[0] = {rd_a, wr_a, d0_a, d1_a, busy_a, addr_a, wd_a, r0_a, r1_a};
    assign obs[1] = {rd_b, wr_b, d0_b, d1_b, busy_b, addr_b, wd_b, r0_b, r1_b};

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: a transaction is a timeline counted in edges since acceptance.
    // phase 0 = strobe, phase wc+1 = done, phase wc+2 = back to idle; -1 = idle.
    int         wc    [2] = '{1, 0};
    int         phase [2];
    bit         last  [2];
    bit         mwin  [2];
    bit         mwe   [2];
    logic [2:0] maddr [2];
    logic [7:0] mwd   [2];
    logic [7:0] mr0   [2];
    logic [7:0] mr1   [2];

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                phase[k] = -1; last[k] = 1'b1; mwin[k] = 1'b0; mwe[k] = 1'b0;
                maddr[k] = '0; mwd[k] = '0; mr0[k] = '0; mr1[k] = '0;
            end else if (phase[k] < 0) begin
                if (req0 || req1) begin
                    mwin[k]  = (req0 && req1) ? !last[k] : req1;
                    mwe[k]   = mwin[k] ? we1 : we0;
                    maddr[k] = mwin[k] ? addr1 : addr0;
                    mwd[k]   = mwin[k] ? wdata1 : wdata0;
                    phase[k] = 0;
                end
            end else begin
                phase[k]++;
                if (phase[k] == wc[k] + 1) begin
                    last[k] = mwin[k];
                    if (!mwe[k]) begin
                        if (mwin[k]) mr1[k] = rdata;
                        else         mr0[k] = rdata;
                    end
                end else if (phase[k] == wc[k] + 2) begin
                    phase[k] = -1;
                end
            end
        end
    endtask

    function automatic logic [31:0] expected(input int k);
        bit strobe, done;
        strobe = (phase[k] == 0);
        done   = (phase[k] == wc[k] + 1);
        return {strobe && !mwe[k], strobe && mwe[k], done && !mwin[k], done && mwin[k],
                phase[k] >= 0, maddr[k], mwd[k], mr0[k], mr1[k]};
    endfunction

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        chk({tag, "/w1"}, obs[0], expected(0));
        chk({tag, "/w0"}, obs[1], expected(1));
        @(negedge clk);
    endtask

    task automatic randomize_inputs(input int mode);
        we0    = 1'($urandom);
        we1    = 1'($urandom);
        addr0  = 3'($urandom);
        addr1  = 3'($urandom);
        wdata0 = 8'($urandom);
        wdata1 = 8'($urandom);
        rdata  = 8'($urandom);
        case (mode)
            1:       begin req0 = 1'b1; req1 = 1'b1; end
            2:       begin req0 = 1'b1; req1 = 1'b0; end
            default: begin
                req0 = ($urandom_range(0, 9) < 6);
                req1 = ($urandom_range(0, 9) < 6);
            end
        endcase
        rst = (mode == 0) && ($urandom_range(0, 79) == 0);
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; rdata = '0;
        for (int k = 0; k < 2; k++) phase[k] = -1;
        @(negedge clk);
        cycle("reset");
        cycle("reset");

        // Contention held from reset: requester 0 must win first.
        rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            randomize_inputs(1);
            cycle("contend");
        end
        for (int i = 0; i < 200; i++) begin
            randomize_inputs(2);
            cycle("lone0");
        end
        for (int i = 0; i < 1500; i++) begin
            randomize_inputs(0);
            cycle("random");
        end
        rst = 1'b1;
        cycle("final_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
